// File: rtl/axi_wdata_router_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_wdata_router_pkg : shared AXI widths for the W-channel router
// Revision: 1.0
// ----------------------------------------------------------------------------
package axi_wdata_router_pkg;

   localparam int AXI_DATA_BITS = 32;
   localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;
   localparam int AXI_LEN_BITS  = 8;

   function automatic int route_width(input int sel_w);
      return sel_w + AXI_LEN_BITS;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_wdata_router_route_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// route_fifo : in-order queue of {slave select, burst length} per AW burst
// Revision: 1.0
// ----------------------------------------------------------------------------
module route_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   // Full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_wdata_router.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_wdata_router : steers master W beats to slaves in AW order, checks WLAST
// Revision: 1.0
// ----------------------------------------------------------------------------
module axi_wdata_router
   import axi_wdata_router_pkg::*;
#(
   parameter int NUM_SLAVES = 3,
   parameter int DEPTH      = 4,
   parameter int SEL_W      = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                aw_push,
   input  logic [SEL_W-1:0]                    aw_sel,
   input  logic [AXI_LEN_BITS-1:0]             aw_len,
   output logic                                aw_full,
   input  logic [AXI_DATA_BITS-1:0]            WDATA_M1,
   input  logic [AXI_STRB_BITS-1:0]            WSTRB_M1,
   input  logic                                WLAST_M1,
   input  logic                                WVALID_M1,
   output logic                                WREADY_M1,
   output logic [NUM_SLAVES*AXI_DATA_BITS-1:0] WDATA_S,
   output logic [NUM_SLAVES*AXI_STRB_BITS-1:0] WSTRB_S,
   output logic [NUM_SLAVES-1:0]               WLAST_S,
   output logic [NUM_SLAVES-1:0]               WVALID_S,
   input  logic [NUM_SLAVES-1:0]               WREADY_S,
   output logic                                wlast_err,
   output logic                                dec_err
);

   localparam int RW = route_width(SEL_W);

   logic [RW-1:0]           head;
   logic                    empty;
   logic                    pop;
   logic [SEL_W-1:0]        head_sel;
   logic [AXI_LEN_BITS-1:0] head_len;
   logic [AXI_LEN_BITS-1:0] beat_cnt;
   logic                    live;
   logic                    mapped;
   logic                    is_last;
   logic                    accept;
   logic                    slave_rdy;
   logic [NUM_SLAVES-1:0]   lane_sel;

   route_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) u_route_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (aw_push),
      .pop   (pop),
      .din   ({aw_sel, aw_len}),
      .full  (aw_full),
      .empty (empty),
      .head  (head)
   );

   assign {head_sel, head_len} = head;

   // Gating with rst keeps a burst caught by reset from handshaking or pulsing errors.
   assign live    = rst & ~empty;
   assign mapped  = ({1'b0, head_sel} < (SEL_W+1)'(NUM_SLAVES));
   assign is_last = (beat_cnt == head_len);

   always_comb begin
      lane_sel  = '0;
      slave_rdy = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (live && mapped && (head_sel == SEL_W'(i))) begin
            lane_sel[i] = 1'b1;
            slave_rdy   = WREADY_S[i];
         end
      end
   end

   // Unmapped bursts are sunk here so the master never deadlocks on a bad address.
   assign WREADY_M1 = live & WVALID_M1 & (mapped ? slave_rdy : 1'b1);
   assign accept    = WVALID_M1 & WREADY_M1;
   assign pop       = accept & is_last;
   assign wlast_err = accept & (WLAST_M1 != is_last);
   assign dec_err   = pop & ~mapped;

   for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_lane
      assign WVALID_S[i] = lane_sel[i] & WVALID_M1;
      assign WLAST_S[i]  = lane_sel[i] & is_last;
      assign WDATA_S[i*AXI_DATA_BITS +: AXI_DATA_BITS] = WDATA_M1;
      assign WSTRB_S[i*AXI_STRB_BITS +: AXI_STRB_BITS] =
         WVALID_S[i] ? WSTRB_M1 : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         beat_cnt <= '0;
      end else if (pop) begin
         beat_cnt <= '0;
      end else if (accept) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_wdata_router.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_axi_wdata_router : directed self-checking bench for axi_wdata_router
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_axi_wdata_router;
   import axi_wdata_router_pkg::*;

   localparam int NS = 3;
   localparam int DW = AXI_DATA_BITS;
   localparam int SW = AXI_STRB_BITS;
   localparam int LW = AXI_LEN_BITS;

   logic             clk;
   logic             rst;
   logic             aw_push;
   logic [1:0]       aw_sel;
   logic [LW-1:0]    aw_len;
   logic             aw_full;
   logic [DW-1:0]    WDATA_M1;
   logic [SW-1:0]    WSTRB_M1;
   logic             WLAST_M1;
   logic             WVALID_M1;
   logic             WREADY_M1;
   logic [NS*DW-1:0] WDATA_S;
   logic [NS*SW-1:0] WSTRB_S;
   logic [NS-1:0]    WLAST_S;
   logic [NS-1:0]    WVALID_S;
   logic [NS-1:0]    WREADY_S;
   logic             wlast_err;
   logic             dec_err;

   int n_checks = 0;
   int n_fail   = 0;

   axi_wdata_router #(
      .NUM_SLAVES (NS),
      .DEPTH      (4),
      .SEL_W      (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .aw_push   (aw_push),
      .aw_sel    (aw_sel),
      .aw_len    (aw_len),
      .aw_full   (aw_full),
      .WDATA_M1  (WDATA_M1),
      .WSTRB_M1  (WSTRB_M1),
      .WLAST_M1  (WLAST_M1),
      .WVALID_M1 (WVALID_M1),
      .WREADY_M1 (WREADY_M1),
      .WDATA_S   (WDATA_S),
      .WSTRB_S   (WSTRB_S),
      .WLAST_S   (WLAST_S),
      .WVALID_S  (WVALID_S),
      .WREADY_S  (WREADY_S),
      .wlast_err (wlast_err),
      .dec_err   (dec_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [1:0]    sels  [4] = '{2'd0, 2'd2, 2'd1, 2'd0};
   logic [NS-1:0] lanes [4] = '{3'b001, 3'b100, 3'b010, 3'b001};
   logic [3:0]    strb;

   initial begin
      rst = 1'b0; aw_push = 1'b0; aw_sel = '0; aw_len = '0;
      WDATA_M1 = '0; WSTRB_M1 = '0; WLAST_M1 = 1'b0; WVALID_M1 = 1'b1; WREADY_S = '1;
      step(); step();
      chk("rst_wready", WREADY_M1, 0);
      chk("rst_wvalid", WVALID_S, 0);
      chk("rst_full", aw_full, 0);
      chk("rst_errs", {wlast_err, dec_err}, 0);
      rst = 1'b1;

      // Single 4-beat burst to slave 1; the fresh entry must not route in its push cycle.
      aw_push = 1'b1; aw_sel = 2'd1; aw_len = 8'd3; #1;
      chk("t1_no_bypass", WREADY_M1, 0);
      step(); aw_push = 1'b0;
      for (int b = 0; b < 4; b++) begin
         strb = 4'hF - 4'(b);
         WDATA_M1 = 32'hA5A5_0000 + 32'(b); WSTRB_M1 = strb; WLAST_M1 = (b == 3); #1;
         chk("t1_valid", WVALID_S, 3'b010);
         chk("t1_ready", WREADY_M1, 1);
         chk("t1_last", WLAST_S, (b == 3) ? 3'b010 : 3'b000);
         chk("t1_data", WDATA_S[DW +: DW], 32'hA5A5_0000 + 32'(b));
         chk("t1_strb", WSTRB_S, {4'h0, strb, 4'h0});
         chk("t1_errs", {wlast_err, dec_err}, 0);
         step();
      end
      #1;
      chk("t1_popped", WREADY_M1, 0);

      // Fill the queue, try pushes while full, then drain in order.
      WVALID_M1 = 1'b0; WLAST_M1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         aw_push = 1'b1; aw_sel = sels[k]; aw_len = 8'd0;
         step();
      end
      chk("t2_full", aw_full, 1);
      aw_sel = 2'd1;
      step();
      chk("t2_still_full", aw_full, 1);
      for (int k = 0; k < 4; k++) begin
         aw_push = (k == 0); WVALID_M1 = 1'b1; #1;
         chk("t2_route", WVALID_S, lanes[k]);
         chk("t2_last", WLAST_S, lanes[k]);
         chk("t2_ready", WREADY_M1, 1);
         step();
         aw_push = 1'b0;
         if (k == 0) chk("t2_full_clr", aw_full, 0);
      end
      #1;
      chk("t2_empty", WREADY_M1, 0);

      // Unmapped index 3 is sunk and flagged on its final beat.
      WVALID_M1 = 1'b0;
      aw_push = 1'b1; aw_sel = 2'd3; aw_len = 8'd1;
      step(); aw_push = 1'b0;
      for (int b = 0; b < 2; b++) begin
         WVALID_M1 = 1'b1; WLAST_M1 = (b == 1); #1;
         chk("t3_valid", WVALID_S, 0);
         chk("t3_ready", WREADY_M1, 1);
         chk("t3_dec", dec_err, (b == 1));
         chk("t3_wlast_err", wlast_err, 0);
         step();
      end
      #1;
      chk("t3_empty", WREADY_M1, 0);

      // Early WLAST on beat 2 of 3: error on beat 2 and on the missing WLAST of beat 3.
      WVALID_M1 = 1'b0;
      aw_push = 1'b1; aw_sel = 2'd0; aw_len = 8'd2;
      step(); aw_push = 1'b0;
      for (int b = 0; b < 3; b++) begin
         WVALID_M1 = 1'b1; WLAST_M1 = (b == 1); #1;
         chk("t4_ready", WREADY_M1, 1);
         chk("t4_werr", wlast_err, (b >= 1));
         chk("t4_last", WLAST_S, (b == 2) ? 3'b001 : 3'b000);
         step();
      end
      #1;
      chk("t4_empty", WREADY_M1, 0);

      // Slave 2 stalls for 5 cycles after beat 1; WLAST_S must still land on beat 4.
      WVALID_M1 = 1'b0;
      aw_push = 1'b1; aw_sel = 2'd2; aw_len = 8'd3;
      step(); aw_push = 1'b0;
      WVALID_M1 = 1'b1; WLAST_M1 = 1'b0; #1;
      chk("t5_beat0", WREADY_M1, 1);
      step();
      WREADY_S = 3'b011;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t5_stall", WREADY_M1, 0);
         chk("t5_valid", WVALID_S, 3'b100);
         chk("t5_last", WLAST_S, 0);
         step();
      end
      WREADY_S = 3'b111;
      for (int b = 1; b < 4; b++) begin
         WLAST_M1 = (b == 3); #1;
         chk("t5_ready", WREADY_M1, 1);
         chk("t5_blast", WLAST_S, (b == 3) ? 3'b100 : 3'b000);
         chk("t5_errs", {wlast_err, dec_err}, 0);
         step();
      end
      #1;
      chk("t5_empty", WREADY_M1, 0);

      // Reset mid-burst discards the route and the partial beat count.
      WVALID_M1 = 1'b0;
      aw_push = 1'b1; aw_sel = 2'd1; aw_len = 8'd3;
      step(); aw_push = 1'b0;
      WVALID_M1 = 1'b1; WLAST_M1 = 1'b0; #1;
      chk("t6_beat0", WREADY_M1, 1);
      step();
      rst = 1'b0; #1;
      chk("t6_rst_ready", WREADY_M1, 0);
      chk("t6_rst_errs", {wlast_err, dec_err}, 0);
      step();
      rst = 1'b1; #1;
      chk("t6_empty", WREADY_M1, 0);
      chk("t6_wvalid", WVALID_S, 0);
      chk("t6_full", aw_full, 0);
      chk("t6_errs", {wlast_err, dec_err}, 0);
      WVALID_M1 = 1'b0;
      aw_push = 1'b1; aw_sel = 2'd0; aw_len = 8'd0;
      step(); aw_push = 1'b0;
      WVALID_M1 = 1'b1; WLAST_M1 = 1'b1; #1;
      chk("t6_fresh_last", WLAST_S, 3'b001);
      chk("t6_fresh_errs", {wlast_err, dec_err}, 0);
      step();
      WVALID_M1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
